// File: rtl/fifo_vc_umbral_pkg.sv
// Shared definitions for the VC FIFO: threshold field positions, default sizes
// and the push/pop classification used by the occupancy counter.
package fifo_vc_umbral_pkg;

    localparam int UMBRAL_AF_MSB = 7;
    localparam int UMBRAL_AF_LSB = 4;
    localparam int UMBRAL_AE_MSB = 3;
    localparam int UMBRAL_AE_LSB = 0;

    localparam int DATA_W_DEF = 6;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    function automatic op_e op_kind(input logic push, input logic pop);
        return op_e'({pop, push});
    endfunction

endpackage

// File: rtl/fifo_vc_umbral_memoria_dual.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered
// read port; a same-address read and write returns the old word.
module memoria_dual #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is intentionally left uninitialised; only the read register resets.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_vc_umbral.sv
// Virtual-channel FIFO with programmable almost-full/almost-empty thresholds
// and a sticky overflow/underflow error flag.
module fifo_vc_umbral
    import fifo_vc_umbral_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        umbral_VCFC,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              FIFO_full,
    output logic              FIFO_empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              FIFO_error
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;
    logic              push_ok, pop_ok, err_ev;
    logic [7:0]        cnt_ext, af_ext, ae_ext;
    op_e               op;

    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign push_ok = wr_en && (!FIFO_full || rd_en);
    assign pop_ok  = rd_en && !FIFO_empty;
    assign err_ev  = (wr_en && FIFO_full && !rd_en) || (rd_en && FIFO_empty);
    assign op      = op_kind(push_ok, pop_ok);

    assign cnt_ext      = 8'(count);
    assign af_ext       = 8'(umbral_VCFC[UMBRAL_AF_MSB:UMBRAL_AF_LSB]);
    assign ae_ext       = 8'(umbral_VCFC[UMBRAL_AE_MSB:UMBRAL_AE_LSB]);
    assign FIFO_full    = (count == DEPTH_C);
    assign FIFO_empty   = (count == '0);
    assign almost_full  = (cnt_ext >= af_ext);
    assign almost_empty = (cnt_ext <= ae_ext);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_out  <= 1'b0;
            FIFO_error <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case (op)
                OP_PUSH: count <= count + 1'b1;
                OP_POP:  count <= count - 1'b1;
                default: count <= count;
            endcase
            valid_out <= pop_ok;
            if (err_ev) FIFO_error <= 1'b1;
        end
    end

    memoria_dual #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push_ok && !reset),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (pop_ok),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

endmodule
